axi_llc_tag_bist_cmp: RTL and testbench

Checks tag-SRAM read data during the LLC tag BIST and reports per-way pass/fail. Sits directly downstream of the tag pattern generator: it snoops the generator's request, write-enable, index and pattern toward the tag SRAMs, and delays the expected pattern to line up with the read latency. It compares every way's read data against that pattern and returns the per-way result vector and valid strobe the generator aggregates. An optional failure log records the first failing location and a saturating error count for debug.

---
 rtl/axi_llc_tag_bist_cmp.sv | 129 ++++++++++++
 tb/tb_axi_llc_tag_bist_cmp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_tag_bist_cmp.sv
// Tag BIST comparator: delays the generator's expected pattern by the SRAM read latency and
// checks every way's read data against it. Optional failure log enabled by AXI_LLC_BIST_FAIL_LOG_EN.

package axi_llc_pkg;

    typedef struct packed {
        int unsigned SetAssociativity;
        int unsigned IndexLength;
    } llc_cfg_t;

endpackage

module axi_llc_tag_bist_cmp #(
    parameter axi_llc_pkg::llc_cfg_t Cfg = '{SetAssociativity: 32'd4, IndexLength: 32'd8},
    parameter type pattern_t             = logic [7:0],
    parameter type way_ind_t             = logic [Cfg.SetAssociativity-1:0],
    parameter type index_t               = logic [Cfg.IndexLength-1:0],
    parameter int unsigned RamLatency    = 1,
    parameter int unsigned ErrCntWidth   = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          req_i,
    input  logic                                          we_i,
    input  logic [$bits(index_t)-1:0]                     index_i,
    input  logic [$bits(pattern_t)-1:0]                   pattern_i,
    input  logic [Cfg.SetAssociativity*$bits(pattern_t)-1:0] ram_rdata_i,
    input  logic                                          clear_i,
    output logic [Cfg.SetAssociativity-1:0]               bist_res_o,
    output logic                                          bist_res_valid_o,
    output logic                                          inflight_o,
    output logic                                          fail_o,
    output logic [$bits(index_t)-1:0]                     fail_index_o,
    output logic [Cfg.SetAssociativity-1:0]               fail_way_o,
    output logic [ErrCntWidth-1:0]                        err_cnt_o
);

    localparam int unsigned Ways  = Cfg.SetAssociativity;
    localparam int unsigned PatW  = $bits(pattern_t);
    localparam int unsigned IdxW  = $bits(index_t);
    localparam int unsigned Last  = RamLatency - 1;

    logic [RamLatency-1:0] stage_valid_q;
    logic [PatW-1:0]       stage_pattern_q [RamLatency];
    logic [IdxW-1:0]       stage_index_q   [RamLatency];

    logic [Ways-1:0]       way_match;
    logic                  fail_event;

    // Only the valid bits need a reset: stale data behind a cleared valid is never compared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_valid_q <= '0;
        end else begin
            stage_valid_q[0] <= req_i & ~we_i;
            for (int s = 1; s < int'(RamLatency); s++) begin
                stage_valid_q[s] <= stage_valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        stage_pattern_q[0] <= pattern_i;
        stage_index_q[0]   <= index_i;
        for (int s = 1; s < int'(RamLatency); s++) begin
            stage_pattern_q[s] <= stage_pattern_q[s-1];
            stage_index_q[s]   <= stage_index_q[s-1];
        end
    end

    // The result is combinational from the read data so the generator sees the final
    // result in the same cycle the data returns.
    always_comb begin
        way_match = '0;
        for (int w = 0; w < int'(Ways); w++) begin
            way_match[w] = (ram_rdata_i[w*PatW +: PatW] == stage_pattern_q[Last]);
        end
    end

    assign bist_res_valid_o = stage_valid_q[Last];
    assign bist_res_o       = bist_res_valid_o ? way_match : '1;
    assign inflight_o       = |stage_valid_q;
    assign fail_event       = bist_res_valid_o & ~(&bist_res_o);

`ifdef AXI_LLC_BIST_FAIL_LOG_EN

    logic                   fail_q;
    logic [IdxW-1:0]        fail_index_q;
    logic [Ways-1:0]        fail_way_q;
    logic [ErrCntWidth-1:0] err_cnt_q;

    // clear wins over a same-cycle failure; only the first failure is captured,
    // while every failure bumps the saturating counter.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            fail_q       <= 1'b0;
            fail_index_q <= '0;
            fail_way_q   <= '0;
            err_cnt_q    <= '0;
        end else if (fail_event) begin
            if (!fail_q) begin
                fail_q       <= 1'b1;
                fail_index_q <= stage_index_q[Last];
                fail_way_q   <= ~bist_res_o;
            end
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign fail_o       = fail_q;
    assign fail_index_o = fail_index_q;
    assign fail_way_o   = fail_way_q;
    assign err_cnt_o    = err_cnt_q;

`else

    logic unused_log_inputs;
    assign unused_log_inputs = clear_i ^ fail_event ^ (^stage_index_q[Last]);

    assign fail_o       = 1'b0;
    assign fail_index_o = '0;
    assign fail_way_o   = '0;
    assign err_cnt_o    = '0;

`endif

endmodule

// File: tb/tb_axi_llc_tag_bist_cmp.sv
// Bench for axi_llc_tag_bist_cmp: two instances (latency 1 / 8-bit counter, latency 3 / 2-bit
// counter) checked every cycle against a per-read history model.

module tb_axi_llc_tag_bist_cmp;

    localparam int Ways = 4;
    localparam int PatW = 8;
    localparam int IdxW = 8;
    localparam int NCyc = 2000;

    typedef logic [PatW-1:0] pat_t;
    typedef logic [IdxW-1:0] idx_t;
    typedef logic [Ways-1:0] way_t;

    localparam axi_llc_pkg::llc_cfg_t TbCfg = '{SetAssociativity: 32'd4, IndexLength: 32'd8};

    logic clock = 1'b0;
    logic rst, req, we, clear;
    idx_t index;
    pat_t pattern;
    logic [Ways*PatW-1:0] rdata [2];

    way_t res [2];
    logic vld [2];
    logic infl [2];
    logic fail [2];
    idx_t fidx [2];
    way_t fway [2];
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int totalChecks = 0;
    int badChecks   = 0;
    int cyc         = 0;
    int lastRst     = -1;
    int lat [2]     = '{1, 3};
    int cntMax [2]  = '{255, 3};

    bit   issValid [NCyc];
    idx_t issIdx   [NCyc];
    pat_t issPat   [NCyc];
    way_t issMask  [NCyc];

    bit   mFail [2];
    idx_t mIdx  [2];
    way_t mWay  [2];
    int   mCnt  [2];

    always #5 clock = ~clock;

    axi_llc_tag_bist_cmp #(
        .Cfg(TbCfg), .pattern_t(pat_t), .way_ind_t(way_t), .index_t(idx_t),
        .RamLatency(1), .ErrCntWidth(8)
    ) dutLat1 (
        .clk_i(clock), .rst_i(rst), .req_i(req), .we_i(we), .index_i(index),
        .pattern_i(pattern), .ram_rdata_i(rdata[0]), .clear_i(clear),
        .bist_res_o(res[0]), .bist_res_valid_o(vld[0]), .inflight_o(infl[0]),
        .fail_o(fail[0]), .fail_index_o(fidx[0]), .fail_way_o(fway[0]), .err_cnt_o(cnt0)
    );

    axi_llc_tag_bist_cmp #(
        .Cfg(TbCfg), .pattern_t(pat_t), .way_ind_t(way_t), .index_t(idx_t),
        .RamLatency(3), .ErrCntWidth(2)
    ) dutLat3 (
        .clk_i(clock), .rst_i(rst), .req_i(req), .we_i(we), .index_i(index),
        .pattern_i(pattern), .ram_rdata_i(rdata[1]), .clear_i(clear),
        .bist_res_o(res[1]), .bist_res_valid_o(vld[1]), .inflight_o(infl[1]),
        .fail_o(fail[1]), .fail_index_o(fidx[1]), .fail_way_o(fway[1]), .err_cnt_o(cnt1)
    );

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", tag, cyc, actual, expected);
        end
    endtask

    // Drives one cycle of generator inputs, answers pending reads with (possibly corrupted)
    // SRAM data, checks both instances, then advances the model past the clock edge.
    task automatic applyStimulus(input logic r, input logic rq, input logic w, input idx_t ix,
                                 input pat_t p, input way_t m, input logic cl);
        bit   expValid [2];
        way_t expRes   [2];
        bit   expInfl  [2];
        int   src      [2];
        rst = r; req = rq; we = w; index = ix; pattern = p; clear = cl;
        issValid[cyc] = rq & ~w;
        issIdx[cyc]   = ix;
        issPat[cyc]   = p;
        issMask[cyc]  = m;
        for (int i = 0; i < 2; i++) begin
            src[i]      = cyc - lat[i];
            expValid[i] = (src[i] >= 0) && issValid[src[i]] && (src[i] > lastRst);
            expRes[i]   = '1;
            expInfl[i]  = 1'b0;
            for (int k = 1; k <= lat[i]; k++) begin
                if ((cyc - k >= 0) && issValid[cyc-k] && (cyc - k > lastRst)) expInfl[i] = 1'b1;
            end
            for (int wy = 0; wy < Ways; wy++) begin
                if (expValid[i]) begin
                    rdata[i][wy*PatW +: PatW] = issMask[src[i]][wy] ? ~issPat[src[i]] : issPat[src[i]];
                    expRes[i][wy] = ~issMask[src[i]][wy];
                end else begin
                    rdata[i][wy*PatW +: PatW] = pat_t'($urandom);
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("lat%0d_valid", lat[i]), 32'(vld[i]), 32'(expValid[i]));
            checkOutput($sformatf("lat%0d_res", lat[i]), 32'(res[i]), 32'(expRes[i]));
            checkOutput($sformatf("lat%0d_inflight", lat[i]), 32'(infl[i]), 32'(expInfl[i]));
`ifdef AXI_LLC_BIST_FAIL_LOG_EN
            checkOutput($sformatf("lat%0d_fail", lat[i]), 32'(fail[i]), 32'(mFail[i]));
            checkOutput($sformatf("lat%0d_fail_index", lat[i]), 32'(fidx[i]), 32'(mIdx[i]));
            checkOutput($sformatf("lat%0d_fail_way", lat[i]), 32'(fway[i]), 32'(mWay[i]));
            checkOutput($sformatf("lat%0d_err_cnt", lat[i]), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(mCnt[i]));
`else
            checkOutput($sformatf("lat%0d_fail", lat[i]), 32'(fail[i]), 32'd0);
            checkOutput($sformatf("lat%0d_fail_index", lat[i]), 32'(fidx[i]), 32'd0);
            checkOutput($sformatf("lat%0d_fail_way", lat[i]), 32'(fway[i]), 32'd0);
            checkOutput($sformatf("lat%0d_err_cnt", lat[i]), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'd0);
`endif
            if (r || cl) begin
                mFail[i] = 1'b0; mIdx[i] = '0; mWay[i] = '0; mCnt[i] = 0;
            end else if (expValid[i] && (expRes[i] != '1)) begin
                if (!mFail[i]) begin
                    mFail[i] = 1'b1; mIdx[i] = issIdx[src[i]]; mWay[i] = ~expRes[i];
                end
                if (mCnt[i] < cntMax[i]) mCnt[i]++;
            end
        end
        if (r) lastRst = cyc;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; clear = 1'b0; index = '0; pattern = '0;
        rdata[0] = '0; rdata[1] = '0;
        for (int i = 0; i < 2; i++) begin
            mFail[i] = 1'b0; mIdx[i] = '0; mWay[i] = '0; mCnt[i] = 0;
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 8'h00, 4'b0000, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd5, 8'hAA, 4'b0000, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd7, 8'hFF, 4'b0100, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd9, 8'h5A, 4'b0001, 1'b0);
        idle(3);

        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, idx_t'(20 + k), pat_t'($urandom), 4'b0000, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(4);

        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1, 1'b0, idx_t'(40 + k), pat_t'($urandom), way_t'(k % 15 + 1), 1'b0);
        idle(4);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'd60, 8'h3C, 4'b0010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd61, 8'hC3, 4'b1000, 1'b0);
        idle(4);

        for (int k = 0; k < 900; k++) begin
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
                          ($urandom_range(0, 99) < 30), idx_t'($urandom), pat_t'($urandom),
                          ($urandom_range(0, 3) == 0) ? way_t'($urandom) : way_t'(0),
                          ($urandom_range(0, 99) < 3));
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
